// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_loader
// Description : Loads big-endian byte stream into a word-addressed instruction
//               memory and serves combinational CPU fetches from it.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_loader #(
    parameter int WORDS = 32,
    parameter int LEN_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] load_len,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             cpu_stall,
    input  logic [31:0]      addr,
    output logic [31:0]      inst
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [LEN_W:0] c_words = (LEN_W + 1)'(WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_ptr;
    logic [1:0]       r_bcnt;
    logic [23:0]      r_asm;
    logic             r_err;
    logic [31:0]      r_mem [DEPTH];

    logic w_len_ok;
    logic w_accept;
    logic w_xfer;
    logic w_word_last;
    logic w_final;
    logic w_addr_unused;

    assign w_len_ok    = (load_len != '0) && ({1'b0, load_len} <= c_words);
    assign w_accept    = (r_state == S_IDLE) && start && w_len_ok;
    assign w_xfer      = (r_state == S_LOAD) && byte_valid;
    assign w_word_last = w_xfer && (r_bcnt == 2'd3);
    assign w_final     = w_word_last && ((r_ptr + LEN_W'(1)) == r_len);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_LOAD;
            S_LOAD:  if (w_final)  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // The first three bytes accumulate in r_asm; the fourth completes the word
    // directly from byte_data so the write lands on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len  <= '0;
            r_ptr  <= '0;
            r_bcnt <= '0;
            r_asm  <= '0;
            r_err  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_err <= (r_state == S_IDLE) && start && !w_len_ok;
            if (w_accept) begin
                r_len  <= load_len;
                r_ptr  <= '0;
                r_bcnt <= '0;
                r_asm  <= '0;
            end else if (w_xfer) begin
                if (w_word_last) begin
                    r_mem[r_ptr[IDX_W-1:0]] <= {r_asm, byte_data};
                    r_ptr  <= r_ptr + LEN_W'(1);
                    r_bcnt <= '0;
                    r_asm  <= '0;
                end else begin
                    r_asm  <= {r_asm[15:0], byte_data};
                    r_bcnt <= r_bcnt + 2'd1;
                end
            end
        end
    end

    assign byte_ready = (r_state == S_LOAD);
    assign busy       = (r_state == S_LOAD) || (r_state == S_DONE);
    assign cpu_stall  = busy;
    assign done       = (r_state == S_DONE);
    assign err        = r_err;

    // Registered memory gives old-data-on-collision for free.
    assign inst          = r_mem[addr[IDX_W+1:2]];
    assign w_addr_unused = ^{addr[31:IDX_W+2], addr[1:0]};

endmodule
`default_nettype wire

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 Parameter WORDS, default 32, number of 32-bit instruction words held.
REQ-002 Parameter LEN_W, default 6, width of load_len; SHALL hold WORDS.
REQ-003 clk  input  1  single clock for the whole block; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a load session.
REQ-006 load_len  input  LEN_W  number of words to load; sampled when start is accepted.
REQ-007 byte_valid  input  1  byte_data holds a valid byte.
REQ-008 byte_data  input  8  instruction byte stream, most significant byte of each word first.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 busy  output  1  load session in progress.
REQ-011 done  output  1  one-cycle pulse when the last word is written.
REQ-012 err  output  1  one-cycle pulse when start is rejected.
REQ-013 cpu_stall  output  1  holds the CPU PC while instruction memory is being rewritten.
REQ-014 addr  input  32  CPU fetch byte address.
REQ-015 inst  output  32  instruction at word index addr[6:2].

Function
REQ-016 FSM states SHALL be IDLE, LOAD and DONE.
REQ-017 In IDLE, start=1 with 1<=load_len<=WORDS SHALL latch load_len, clear word_ptr and byte_cnt, and enter LOAD next cycle.
REQ-018 In IDLE, start=1 with load_len=0 or load_len>WORDS SHALL pulse err for one cycle and stay in IDLE.
REQ-019 byte_ready SHALL be 1 only in LOAD.
REQ-020 A byte SHALL transfer only on a cycle with byte_valid=1 and byte_ready=1; byte_data is ignored on all other cycles.
REQ-021 Transferred bytes SHALL be assembled big-endian: the 1st byte goes to [31:24], the 2nd to [23:16], the 3rd to [15:8] and the 4th to [7:0].
REQ-022 On the 4th byte's transfer cycle, the complete word SHALL be written to mem[word_ptr]; word_ptr SHALL then increment and byte_cnt SHALL clear.
REQ-023 When the written word is number load_len, the FSM SHALL enter DONE next cycle; word_ptr SHALL never wrap past WORDS-1.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-025 start asserted in LOAD or DONE SHALL be ignored, with no err pulse and no change to the session.
REQ-026 busy SHALL be 1 in LOAD and DONE; cpu_stall SHALL equal busy.
REQ-027 inst SHALL be combinational: mem[addr[6:2]]; addr bits [31:7] and [1:0] are ignored.
REQ-028 When a read hits the word being written in the same cycle, inst SHALL return the old contents; the new value is visible the cycle after.
REQ-029 Words beyond load_len SHALL keep their previous contents.
REQ-030 byte_valid gaps SHALL stall assembly without losing partial bytes; there is no timeout.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force: state IDLE, word_ptr=0, byte_cnt=0, assembly register=0, all mem words=32'h0.
REQ-032 Output values during and after reset: byte_ready=0, busy=0, done=0, err=0, cpu_stall=0, inst=32'h0.
REQ-033 Reset mid-LOAD SHALL abort the session; any partial word SHALL be discarded and no further writes SHALL occur.

Verification
REQ-034 start with load_len=2, then bytes 08 00 00 05 3C 0B 98 76 back-to-back -> mem[0]=32'h08000005 and mem[1]=32'h3C0B9876; done pulses the cycle after byte 8 transfers; addr=32'h4 gives inst=32'h3C0B9876.
REQ-035 Same stream with byte_valid toggled 1/0 each cycle -> identical memory contents; busy and cpu_stall stay high throughout; exactly one done pulse.
REQ-036 start with load_len=0, and separately with load_len=33 -> one-cycle err each time; byte_ready stays 0 and busy stays 0.
REQ-037 Full load with load_len=32 of words 32'h00000000..32'h0000001F -> addr=32'h7C gives inst=32'h1F; state returns to IDLE with no wrap write to mem[0].
REQ-038 rst_n low after 6 bytes of a 2-word load -> mem[0]=32'h0 (reset-cleared) and mem[1]=32'h0; a subsequent fresh load succeeds.
REQ-039 start pulsed mid-LOAD with load_len=5 -> ignored; session completes with the original length.
